// File: rtl/iter_comparator_pkg.sv
// Shared op codes, FSM states and flag mapping for the iterative comparator.
// The ALU decode reuses the same op code values.
package iter_comparator_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] CMP_SLT  = 3'b000;
    localparam logic [2:0] CMP_SLTU = 3'b001;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_NE   = 3'b011;
    localparam logic [2:0] CMP_SGE  = 3'b100;
    localparam logic [2:0] CMP_SGEU = 3'b101;

    function automatic logic cmp_is_signed(input logic [2:0] op);
        return (op == CMP_SLT) || (op == CMP_SGE);
    endfunction

    function automatic logic cmp_flag(
        input logic [2:0] op,
        input logic       lt,
        input logic       eq
    );
        logic f;
        f = 1'b0;
        case (op)
            CMP_SLT, CMP_SLTU: f = lt;
            CMP_EQ:            f = eq;
            CMP_NE:            f = ~eq;
            CMP_SGE, CMP_SGEU: f = ~lt;
            default:           f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/iter_comparator_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module iter_comparator_chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] ca,
    input  logic [CHUNK-1:0] cb,
    output logic             lt,
    output logic             eq
);

    assign lt = (ca < cb);
    assign eq = (ca == cb);

endmodule

// File: rtl/iter_comparator.sv
// Multi-cycle comparator: scans operands MSB chunk first, stops at the
// first differing chunk, result held behind a valid/ready handshake.
import iter_comparator_pkg::*;

module iter_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             lt_o,
    output logic             eq_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_lt;
    logic             r_eq;

    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [31:0]      w_off;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_lt;
    logic             w_eq;
    logic             w_accept;
    logic             w_hit;

    // Flipping the sign bits turns a signed compare into an unsigned one.
    assign w_a_in = cmp_is_signed(op) ? {~a[WIDTH-1], a[WIDTH-2:0]} : a;
    assign w_b_in = cmp_is_signed(op) ? {~b[WIDTH-1], b[WIDTH-2:0]} : b;

    assign w_off = 32'(r_idx) * 32'(CHUNK);
    assign w_ca  = CHUNK'(r_a >> w_off);
    assign w_cb  = CHUNK'(r_b >> w_off);

    iter_comparator_chunk_cmp #(
        .CHUNK(CHUNK)
    ) u_chunk_cmp (
        .ca(w_ca),
        .cb(w_cb),
        .lt(w_lt),
        .eq(w_eq)
    );

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_hit    = !w_eq || (r_idx == '0);

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_SCAN;
            end
            S_SCAN: begin
                if (w_hit) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_idx    <= IDX_TOP;
            r_result <= '0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= w_a_in;
                r_b   <= w_b_in;
                r_op  <= op;
                r_idx <= IDX_TOP;
            end
            if (r_state == S_SCAN) begin
                if (w_hit) begin
                    r_lt     <= w_lt;
                    r_eq     <= w_eq;
                    r_result <= WIDTH'(cmp_flag(r_op, w_lt, w_eq));
                end else begin
                    r_idx <= r_idx - 1'b1;
                end
            end
        end
    end

    assign result = r_result;
    assign lt_o   = r_lt;
    assign eq_o   = r_eq;

endmodule

// File: tb/tb_iter_comparator.sv
// Randomised and directed bench for iter_comparator (32/8 and 8/8 builds).
module tb_iter_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, lt_o, eq_o;
    logic [31:0] a, b, result;
    logic [2:0]  op;

    logic        s8_in_valid, s8_in_ready, s8_out_valid, s8_out_ready;
    logic        s8_lt_o, s8_eq_o;
    logic [7:0]  s8_a, s8_b, s8_result;
    logic [2:0]  s8_op;

    int errors = 0;
    int checks = 0;

    iter_comparator #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .lt_o(lt_o), .eq_o(eq_o)
    );

    iter_comparator #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(s8_in_valid), .in_ready(s8_in_ready),
        .a(s8_a), .b(s8_b), .op(s8_op),
        .out_valid(s8_out_valid), .out_ready(s8_out_ready),
        .result(s8_result), .lt_o(s8_lt_o), .eq_o(s8_eq_o)
    );

    // Reference: plain integer compare plus "first differing chunk" latency.
    function automatic void model(
        input  logic [31:0] ma, mb,
        input  logic [2:0]  mop,
        input  int          w,
        output logic        mlt, meq, mflag,
        output int          medges
    );
        longint sa, sb;
        int nch;
        nch = w / 8;
        sa = longint'(ma);
        sb = longint'(mb);
        if (mop == 3'd0 || mop == 3'd4) begin
            if (ma[w-1]) sa = sa - (longint'(1) << w);
            if (mb[w-1]) sb = sb - (longint'(1) << w);
        end
        mlt = (sa < sb);
        meq = (ma == mb);
        case (mop)
            3'd0, 3'd1: mflag = mlt;
            3'd2:       mflag = meq;
            3'd3:       mflag = ~meq;
            3'd4, 3'd5: mflag = ~mlt;
            default:    mflag = 1'b0;
        endcase
        medges = nch;
        for (int i = nch - 1; i >= 0; i--) begin
            if (((ma >> (i * 8)) & 32'hFF) != ((mb >> (i * 8)) & 32'hFF)) begin
                medges = nch - i;
                break;
            end
        end
    endfunction

    // Edges counted from the accepting edge to the first out_valid sample.
    task automatic run_op(
        input  logic [31:0] ta, tb_,
        input  logic [2:0]  top,
        output logic [31:0] res,
        output logic        rlt, req,
        output int          edges
    );
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_; op = top;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        edges = 0;
        while (edges < 60) begin
            @(posedge clk); #1;
            edges++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            errors++; checks++;
            $display("FAIL timeout: out_valid=%0b after %0d edges, required 1", out_valid, edges);
        end
        res = result; rlt = lt_o; req = eq_o;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op8(
        input  logic [7:0] ta, tb_,
        input  logic [2:0] top,
        output logic [7:0] res,
        output int         edges
    );
        @(negedge clk);
        s8_in_valid = 1'b1; s8_a = ta; s8_b = tb_; s8_op = top;
        @(posedge clk); #1;
        s8_in_valid = 1'b0;
        edges = 0;
        while (edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (s8_out_valid) break;
        end
        if (!s8_out_valid) begin
            errors++; checks++;
            $display("FAIL timeout8: out_valid=%0b after %0d edges, required 1", s8_out_valid, edges);
        end
        res = s8_result;
        s8_out_ready = 1'b1;
        @(posedge clk); #1;
        s8_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0;
        s8_in_valid = 0; s8_out_ready = 0; s8_a = 0; s8_b = 0; s8_op = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, result, lt_o, eq_o} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset32: rdy=%0b vld=%0b res=%h lt=%0b eq=%0b, required 1 0 0 0 0",
                     in_ready, out_valid, result, lt_o, eq_o);
        end
        checks++;
        if ({s8_in_ready, s8_out_valid, s8_result} !== {1'b1, 1'b0, 8'h0}) begin
            errors++;
            $display("FAIL reset8: rdy=%0b vld=%0b res=%h, required 1 0 0",
                     s8_in_ready, s8_out_valid, s8_result);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: rdy=%0b vld=%0b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678,
                                32'h12345678, 32'h00000010, 32'h00000010};
        logic [31:0] vb [6] = '{32'h00000001, 32'h00000001, 32'h12345678,
                                32'h12345678, 32'h00000011, 32'h00000011};
        logic [2:0]  vo [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd5};
        logic [31:0] vr [6] = '{32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0};
        logic        vl [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        ve [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int          vd [6] = '{1, 1, 4, 4, 4, 4};
        logic [31:0] res;
        logic        rlt, req;
        int          edges;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vo[i], res, rlt, req, edges);
            checks++;
            if (res !== vr[i]) begin
                errors++;
                $display("FAIL dir%0d result: got %h, required %h", i, res, vr[i]);
            end
            checks++;
            if (rlt !== vl[i] || req !== ve[i]) begin
                errors++;
                $display("FAIL dir%0d flags: lt=%0b eq=%0b, required lt=%0b eq=%0b",
                         i, rlt, req, vl[i], ve[i]);
            end
            checks++;
            if (edges != vd[i]) begin
                errors++;
                $display("FAIL dir%0d latency: got %0d edges, required %0d", i, edges, vd[i]);
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic        rlt, req;
        int          edges;
        run_op(32'hFFFFFFFF, 32'h00000001, 3'd0, res, rlt, req, edges);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'h1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: vld=%0b res=%h rdy=%0b, required 1 00000001 0",
                         c, out_valid, result, in_ready);
            end
        end
        handshake();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: rdy=%0b vld=%0b, required 1 0", in_ready, out_valid);
        end
        run_op(32'hA5A5A5A5, 32'hA5A5A5A5, 3'd2, res, rlt, req, edges);
        checks++;
        if (res !== 32'h1 || edges != 4) begin
            errors++;
            $display("FAIL b2b: res=%h edges=%0d, required 00000001 4", res, edges);
        end
        handshake();
    endtask

    task automatic test_random();
        logic [31:0] ta, tb_, res;
        logic [2:0]  top;
        logic        rlt, req, mlt, meq, mflag;
        int          edges, medges, k, hold;
        for (int n = 0; n < 300; n++) begin
            ta = $urandom;
            tb_ = ($urandom_range(0, 1) == 0) ? ta : 32'($urandom);
            k = $urandom_range(0, 4);
            if (k < 4) tb_[k*8 +: 8] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) tb_[31] = ~tb_[31];
            top = 3'($urandom_range(0, 7));
            model(ta, tb_, top, 32, mlt, meq, mflag, medges);
            run_op(ta, tb_, top, res, rlt, req, edges);
            checks++;
            if (res !== {31'b0, mflag} || rlt !== mlt || req !== meq || edges != medges) begin
                errors++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: res=%h lt=%0b eq=%0b edges=%0d, required %h %0b %0b %0d",
                         n, top, ta, tb_, res, rlt, req, edges, {31'b0, mflag}, mlt, meq, medges);
            end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1; a = $urandom; b = $urandom;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            handshake();
        end
    endtask

    task automatic test_rst_scan();
        logic [31:0] res;
        logic [7:0]  r8;
        logic        rlt, req, seen;
        int          edges;
        run_op(32'hCAFEF00D, 32'hCAFEF00D, 3'd2, res, rlt, req, edges);
        handshake();
        @(negedge clk);
        in_valid = 1'b1; a = 32'h0BADBEEF; b = 32'h0BADBEEF; op = 3'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, result, lt_o, eq_o} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_scan: rdy=%0b vld=%0b res=%h lt=%0b eq=%0b, required 1 0 0 0 0",
                     in_ready, out_valid, result, lt_o, eq_o);
        end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop: out_valid seen=%0b, required 0", seen);
        end

        run_op8(8'h10, 8'h11, 3'd1, r8, edges);
        checks++;
        if (r8 !== 8'h01 || edges != 1) begin
            errors++;
            $display("FAIL n1_sltu: res=%h edges=%0d, required 01 1", r8, edges);
        end
        run_op8(8'h5A, 8'h5A, 3'd2, r8, edges);
        checks++;
        if (r8 !== 8'h01 || edges != 1) begin
            errors++;
            $display("FAIL n1_eq: res=%h edges=%0d, required 01 1", r8, edges);
        end
        run_op8(8'h80, 8'h01, 3'd4, r8, edges);
        checks++;
        if (r8 !== 8'h00 || edges != 1) begin
            errors++;
            $display("FAIL n1_sge: res=%h edges=%0d, required 00 1", r8, edges);
        end
        @(negedge clk);
        s8_in_valid = 1'b1; s8_a = 8'h33; s8_b = 8'h33; s8_op = 3'd2;
        @(posedge clk); #1;
        s8_in_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({s8_in_ready, s8_out_valid, s8_result} !== {1'b1, 1'b0, 8'h0}) begin
            errors++;
            $display("FAIL rst8: rdy=%0b vld=%0b res=%h, required 1 0 00",
                     s8_in_ready, s8_out_valid, s8_result);
        end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (s8_out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst8_drop: out_valid seen=%0b, required 0", seen);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_rst_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
